// File: rtl/noc_tok_south_arb.sv
// South token NoC arbiter: four OCP-lite token ports, round-robin onto one link.
// Optional NOC_TOK_SOUTH_ARB_PERF_CNT_EN adds saturating per-port grant counters.
module noc_tok_south_arb #(
  parameter int N_PORTS = 4,
  parameter int FLIT_W  = 42,
  parameter int CNT_W   = 16
) (
  input  logic                        i_noc_clk,
  input  logic                        i_noc_rst,
  input  logic [N_PORTS-1:0][7:0]     i_init_tok_ocpl_s_maddr,
  input  logic [N_PORTS-1:0][2:0]     i_init_tok_ocpl_s_mcmd,
  input  logic [N_PORTS-1:0][7:0]     i_init_tok_ocpl_s_mdata,
  output logic [N_PORTS-1:0]          o_init_tok_ocpl_s_scmdaccept,
  input  logic [N_PORTS-1:0]          i_pwr_tok_idle_req,
  output logic [N_PORTS-1:0]          o_pwr_tok_idle_ack,
  output logic [N_PORTS-1:0]          o_pwr_tok_idle_val,
  output logic [N_PORTS-1:0]          o_cmd_err,
  output logic [FLIT_W-1:0]           o_egress_data,
  output logic                        o_egress_head,
  output logic                        o_egress_tail,
  output logic                        o_egress_vld,
`ifdef NOC_TOK_SOUTH_ARB_PERF_CNT_EN
  input  logic                        i_egress_rdy,
  output logic [N_PORTS-1:0][CNT_W-1:0] o_grant_cnt
`else
  input  logic                        i_egress_rdy
`endif
);

  localparam int SW = 2;
  localparam int PAD = FLIT_W - SW - 16;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } tok_ent_t;

  logic [N_PORTS-1:0]   buf_vld;
  tok_ent_t [N_PORTS-1:0] buf_ent;
  logic [N_PORTS-1:0]   fence;
  logic [N_PORTS-1:0]   cmd_err;
  logic [SW-1:0]        ptr;
  logic                 out_vld;
  logic [SW-1:0]        out_src;
  logic [FLIT_W-1:0]    out_data;

  logic [N_PORTS-1:0]   acc;
  logic [N_PORTS-1:0]   wr;
  logic [N_PORTS-1:0]   ill;
  logic [N_PORTS-1:0]   idle_val;
  logic [SW-1:0]        cand;
  logic [SW-1:0]        win;
  logic                 found;
  logic                 gnt;

  // Accept decode: a port takes a command only with an empty buffer and no fence.
  always_comb begin
    acc = '0;
    wr  = '0;
    ill = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      acc[i] = (i_init_tok_ocpl_s_mcmd[i] != 3'd0)
             & ~buf_vld[i] & ~fence[i];
      wr[i]  = acc[i] & (i_init_tok_ocpl_s_mcmd[i] == 3'd1);
      ill[i] = acc[i] & (i_init_tok_ocpl_s_mcmd[i] != 3'd1);
    end
  end

  // Round-robin search starting one past the last winner.
  always_comb begin
    cand  = '0;
    win   = ptr;
    found = 1'b0;
    for (int k = 1; k <= N_PORTS; k++) begin
      cand = SW'((int'(ptr) + k) % N_PORTS);
      if (!found && buf_vld[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
    gnt = found & (~out_vld | i_egress_rdy);
  end

  // Capture buffers, fence, error flags, pointer and the egress register.
  always_ff @(posedge i_noc_clk) begin
    if (i_noc_rst) begin
      buf_vld  <= '0;
      buf_ent  <= '0;
      fence    <= '0;
      cmd_err  <= '0;
      ptr      <= SW'(N_PORTS - 1);
      out_vld  <= 1'b0;
      out_src  <= '0;
      out_data <= '0;
    end else begin
      fence   <= i_pwr_tok_idle_req;
      cmd_err <= cmd_err | ill;
      for (int i = 0; i < N_PORTS; i++) begin
        if (wr[i]) begin
          buf_vld[i]      <= 1'b1;
          buf_ent[i].addr <= i_init_tok_ocpl_s_maddr[i];
          buf_ent[i].data <= i_init_tok_ocpl_s_mdata[i];
        end
      end
      if (gnt) begin
        buf_vld[win] <= 1'b0;
        ptr          <= win;
        out_vld      <= 1'b1;
        out_src      <= win;
        out_data     <= {win, buf_ent[win].addr,
                         buf_ent[win].data, {PAD{1'b0}}};
      end else if (out_vld && i_egress_rdy) begin
        out_vld <= 1'b0;
      end
    end
  end

  // Idle means nothing buffered and nothing waiting in the egress register.
  always_comb begin
    idle_val = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      idle_val[i] = ~buf_vld[i]
                  & ~(out_vld & (out_src == SW'(i)));
    end
  end

  assign o_init_tok_ocpl_s_scmdaccept = acc;
  assign o_pwr_tok_idle_val = idle_val;
  assign o_pwr_tok_idle_ack = fence & idle_val;
  assign o_cmd_err          = cmd_err;
  assign o_egress_data      = out_data;
  assign o_egress_vld       = out_vld;
  assign o_egress_head      = out_vld;
  assign o_egress_tail      = out_vld;

`ifdef NOC_TOK_SOUTH_ARB_PERF_CNT_EN
  logic [N_PORTS-1:0][CNT_W-1:0] cnt;

  // Saturating grant counters per port.
  always_ff @(posedge i_noc_clk) begin
    if (i_noc_rst) begin
      cnt <= '0;
    end else if (gnt && (cnt[win] != {CNT_W{1'b1}})) begin
      cnt[win] <= cnt[win] + 1'b1;
    end
  end

  assign o_grant_cnt = cnt;
`endif

endmodule

// File: tb/tb_noc_tok_south_arb.sv
// Directed bench for noc_tok_south_arb.
// Drives and samples on the falling edge; expected values are hand-computed.
module tb_noc_tok_south_arb;

  logic             clk = 1'b0;
  logic             rst;
  logic [3:0][7:0]  maddr;
  logic [3:0][2:0]  mcmd;
  logic [3:0][7:0]  mdata;
  logic [3:0]       acc;
  logic [3:0]       idle_req;
  logic [3:0]       idle_ack;
  logic [3:0]       idle_val;
  logic [3:0]       cmd_err;
  logic [41:0]      edata;
  logic             ehead;
  logic             etail;
  logic             evld;
  logic             erdy;
`ifdef NOC_TOK_SOUTH_ARB_PERF_CNT_EN
  logic [3:0][15:0] gcnt;
`endif

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  noc_tok_south_arb dut (
    .i_noc_clk                    (clk),
    .i_noc_rst                    (rst),
    .i_init_tok_ocpl_s_maddr      (maddr),
    .i_init_tok_ocpl_s_mcmd       (mcmd),
    .i_init_tok_ocpl_s_mdata      (mdata),
    .o_init_tok_ocpl_s_scmdaccept (acc),
    .i_pwr_tok_idle_req           (idle_req),
    .o_pwr_tok_idle_ack           (idle_ack),
    .o_pwr_tok_idle_val           (idle_val),
    .o_cmd_err                    (cmd_err),
    .o_egress_data                (edata),
    .o_egress_head                (ehead),
    .o_egress_tail                (etail),
    .o_egress_vld                 (evld),
`ifdef NOC_TOK_SOUTH_ARB_PERF_CNT_EN
    .i_egress_rdy                 (erdy),
    .o_grant_cnt                  (gcnt)
`else
    .i_egress_rdy                 (erdy)
`endif
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [41:0] flit(input logic [1:0] s,
                                       input logic [7:0] a,
                                       input logic [7:0] d);
    return {s, a, d, 24'h0};
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    maddr    = '0;
    mcmd     = '0;
    mdata    = '0;
    idle_req = '0;
    erdy     = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    maddr    = '0;
    mcmd     = '0;
    mdata    = '0;
    idle_req = '0;
    erdy     = 1'b1;

    // Reset values
    do_reset();
    chk("rst_vld", 64'(evld), 64'd0);
    chk("rst_head", 64'(ehead), 64'd0);
    chk("rst_tail", 64'(etail), 64'd0);
    chk("rst_data", 64'(edata), 64'd0);
    chk("rst_idle_val", 64'(idle_val), 64'hF);
    chk("rst_idle_ack", 64'(idle_ack), 64'h0);
    chk("rst_cmd_err", 64'(cmd_err), 64'h0);
    chk("rst_acc", 64'(acc), 64'h0);
`ifdef NOC_TOK_SOUTH_ARB_PERF_CNT_EN
    chk("rst_cnt", 64'(gcnt), 64'h0);
`endif

    // Single write on port 2, two-cycle latency
    mcmd[2]  = 3'd1;
    maddr[2] = 8'h5A;
    mdata[2] = 8'hC3;
    #1 chk("p2_acc", 64'(acc), 64'b0100);
    step();
    mcmd = '0;
    chk("p2_t1_vld", 64'(evld), 64'd0);
    chk("p2_t1_idle", 64'(idle_val), 64'b1011);
    step();
    chk("p2_t2_vld", 64'(evld), 64'd1);
    chk("p2_t2_head", 64'(ehead), 64'd1);
    chk("p2_t2_tail", 64'(etail), 64'd1);
    chk("p2_t2_data", 64'(edata),
        64'(flit(2'd2, 8'h5A, 8'hC3)));
    step();
    chk("p2_t3_vld", 64'(evld), 64'd0);

    // All ports streaming: strict 0,1,2,3 rotation, no gaps
    do_reset();
    for (int i = 0; i < 4; i++) begin
      mcmd[i]  = 3'd1;
      maddr[i] = 8'h10 + 8'(i);
      mdata[i] = 8'h20 + 8'(i);
    end
    #1 chk("rr_acc", 64'(acc), 64'hF);
    step();
    chk("rr_lat_vld", 64'(evld), 64'd0);
    for (int f = 0; f < 8; f++) begin
      step();
      chk($sformatf("rr_vld%0d", f), 64'(evld), 64'd1);
      chk($sformatf("rr_src%0d", f), 64'(edata[41:40]),
          64'(f % 4));
      if (f == 1)
        chk("rr_data1", 64'(edata),
            64'(flit(2'd1, 8'h11, 8'h21)));
    end
`ifdef NOC_TOK_SOUTH_ARB_PERF_CNT_EN
    for (int i = 0; i < 4; i++)
      chk($sformatf("rr_cnt%0d", i), 64'(gcnt[i]), 64'd2);
`endif
    mcmd = '0;
    repeat (8) step();
    chk("rr_drained", 64'(evld), 64'd0);

    // Backpressure on port 1
    do_reset();
    erdy     = 1'b0;
    mcmd[1]  = 3'd1;
    maddr[1] = 8'h11;
    mdata[1] = 8'h22;
    step();
    #1 chk("bp_acc_full", 64'(acc), 64'b0000);
    maddr[1] = 8'h33;
    mdata[1] = 8'h44;
    step();
    chk("bp_vld0", 64'(evld), 64'd1);
    chk("bp_acc_2nd", 64'(acc), 64'b0010);
    for (int c = 0; c < 4; c++) begin
      step();
      chk($sformatf("bp_hold_vld%0d", c), 64'(evld), 64'd1);
      chk($sformatf("bp_hold_data%0d", c), 64'(edata),
          64'(flit(2'd1, 8'h11, 8'h22)));
      chk($sformatf("bp_hold_acc%0d", c), 64'(acc), 64'd0);
    end
    erdy = 1'b1;
    mcmd = '0;
    step();
    chk("bp_b_vld", 64'(evld), 64'd1);
    chk("bp_b_data", 64'(edata),
        64'(flit(2'd1, 8'h33, 8'h44)));
    step();
    chk("bp_end_vld", 64'(evld), 64'd0);

    // Fence on port 3 with a flit stuck in egress
    do_reset();
    erdy     = 1'b0;
    mcmd[3]  = 3'd1;
    maddr[3] = 8'hA3;
    mdata[3] = 8'hB3;
    step();
    mcmd = '0;
    step();
    chk("fn_vld", 64'(evld), 64'd1);
    chk("fn_src", 64'(edata[41:40]), 64'd3);
    idle_req[3] = 1'b1;
    #1 chk("fn_ack_early", 64'(idle_ack), 64'd0);
    step();
    chk("fn_ack_busy", 64'(idle_ack), 64'd0);
    chk("fn_val_busy", 64'(idle_val), 64'b0111);
    mcmd[3] = 3'd1;
    #1 chk("fn_acc_blk", 64'(acc), 64'd0);
    step();
    chk("fn_ack_busy2", 64'(idle_ack), 64'd0);
    erdy = 1'b1;
    step();
    chk("fn_vld_done", 64'(evld), 64'd0);
    chk("fn_val_idle", 64'(idle_val), 64'hF);
    chk("fn_ack", 64'(idle_ack), 64'b1000);
    chk("fn_acc_still", 64'(acc), 64'd0);
    idle_req = '0;
    mcmd     = '0;
    step();
    chk("fn_ack_drop", 64'(idle_ack), 64'd0);
    mcmd[3] = 3'd1;
    #1 chk("fn_acc_resume", 64'(acc), 64'b1000);
    mcmd = '0;

    // Illegal command on port 0
    do_reset();
    mcmd[0] = 3'b010;
    #1 chk("er_acc", 64'(acc), 64'b0001);
    step();
    mcmd = '0;
    chk("er_flag", 64'(cmd_err), 64'b0001);
    chk("er_idle", 64'(idle_val), 64'hF);
    chk("er_vld1", 64'(evld), 64'd0);
    step();
    chk("er_vld2", 64'(evld), 64'd0);
    chk("er_sticky", 64'(cmd_err), 64'b0001);
    step();
    rst = 1'b1;
    step();
    chk("er_rst_clr", 64'(cmd_err), 64'd0);
    rst = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/noc_tok_south_arb.md
# noc_tok_south_arb

Round-robin arbiter in the south token NoC domain. It collects OCP-lite token writes from four AI-core initiator ports, serialises them onto the single south-to-center token egress link as single-flit packets, and handles per-port idle/fence handshakes for power-down. It sits between the `aic_*_init_tok` initiator ports and the `lnk_cross_south_to_center_tok` egress, clocked on the NoC clock.

## Interface
Parameters:
- `N_PORTS`, 4: number of requester ports; the source-ID field is 2 bits, so the maximum is 4.
- `FLIT_W`, 42: egress flit data width.
- `CNT_W`, 16: grant counter width. Only used with `NOC_TOK_SOUTH_ARB_PERF_CNT_EN`.

Ports:
- `i_noc_clk`  in  1: the block's only clock.
- `i_noc_rst`  in  1: synchronous, active-high reset.
- `i_init_tok_ocpl_s_maddr`  in  N_PORTS×8: per-port MAddr.
- `i_init_tok_ocpl_s_mcmd`  in  N_PORTS×3: per-port MCmd. 0 = IDLE, 1 = WR, any other value is illegal.
- `i_init_tok_ocpl_s_mdata`  in  N_PORTS×8: per-port MData.
- `o_init_tok_ocpl_s_scmdaccept`  out  N_PORTS: per-port SCmdAccept.
- `i_pwr_tok_idle_req`  in  N_PORTS: per-port fence request.
- `o_pwr_tok_idle_ack`  out  N_PORTS: per-port fence acknowledge.
- `o_pwr_tok_idle_val`  out  N_PORTS: port has no traffic in flight.
- `o_cmd_err`  out  N_PORTS: sticky flag, set when an illegal MCmd is accepted.
- `o_egress_data`  out  FLIT_W: flit payload.
- `o_egress_head`, `o_egress_tail`, `o_egress_vld`  out  1 each: flit framing and valid.
- `i_egress_rdy`  in  1: egress ready.
- `o_grant_cnt`  out  N_PORTS×CNT_W: per-port grant counters. Only present with `NOC_TOK_SOUTH_ARB_PERF_CNT_EN`.

## Operation
Per-port capture buffer (one entry per port, `buf_vld[i]` plus an 8b addr/8b data field):
- `o_init_tok_ocpl_s_scmdaccept[i] = (mcmd != 0) & ~buf_vld[i] & ~fence[i]`. This is combinational.
- When a WR is accepted, the buffer loads on the next edge.
- When an illegal command is accepted, it is discarded, `o_cmd_err[i]` is set, and the buffer is not loaded.

Arbiter:
- Round-robin pointer `ptr`. Search order is `ptr+1, ptr+2, …` modulo N_PORTS.
- The arbiter grants when the output register is empty, or when `o_egress_vld & i_egress_rdy`.
- On a grant:
  - the output register is loaded;
  - `buf_vld[winner]` is cleared;
  - `ptr` is set to the winner.
- With no request, `ptr` is unchanged.

Flit format:
- [41:40] source index.
- [39:32] MAddr.
- [31:24] MData.
- [23:0] zero.
- `o_egress_head = o_egress_tail = o_egress_vld`.

Fence:
- `fence[i]` is registered from `i_pwr_tok_idle_req[i]`.
- While fenced, the port accepts no new commands. Traffic already buffered for that port still drains.
- `o_pwr_tok_idle_val[i] = ~buf_vld[i] & ~(out_vld & out_src == i)`.
- `o_pwr_tok_idle_ack[i] = fence[i] & o_pwr_tok_idle_val[i]`.
- When the request drops, `fence` clears on the next edge, the ack drops with it, and accepts resume.

Reset values:
- All `buf_vld`, `fence`, `o_cmd_err` and output-register valid bits are 0.
- `ptr = N_PORTS-1`, so port 0 wins first.
- `o_egress_vld`, `head` and `tail` are 0, and `o_egress_data` is 0.
- `o_pwr_tok_idle_val` is all-ones; `o_pwr_tok_idle_ack` is 0.
- Counters are 0.

Reset mid-operation discards all buffered and output flits without emitting them.

## Timing
- Accept in cycle T leads to `o_egress_vld` high in T+2, provided the output register is free.
- Single-port throughput is one token per 2 cycles, because the buffer blocks accepts while occupied.
- Aggregate throughput is 1 flit/cycle with `i_egress_rdy` held high.
- Once `o_egress_vld` is high, data, head and tail stay stable until `i_egress_rdy` is sampled high.
- A grant and a fresh accept on the same port in the same cycle cannot happen, because accept requires `~buf_vld`.
- Idle request high in cycle T gives `fence=1` from T+1. The ack asserts in the first cycle the port has nothing in flight, at the earliest T+1.

## Configuration
`NOC_TOK_SOUTH_ARB_PERF_CNT_EN`:
- Defined: `o_grant_cnt` exists. Each port has a CNT_W-bit counter that increments on every grant to that port, saturates at all-ones, and resets to 0.
- Undefined: the port and the counters are absent. All other behaviour is identical.

## Test plan
- Reset release: all outputs at their reset values; `o_pwr_tok_idle_val` = 4'b1111.
- Port 2 WR, maddr=0x5A, mdata=0xC3, `i_egress_rdy`=1: accept in cycle T; in T+2 `o_egress_data` = {2'd2, 8'h5A, 8'hC3, 24'h0} with head=tail=vld=1 for one cycle.
- All 4 ports WR continuously, rdy=1: grant order 0,1,2,3,0,… with no gaps; with the perf macro, each `o_grant_cnt` equals 2 after 8 flits.
- Port 1 WR while `i_egress_rdy`=0 for 5 cycles: vld holds with data stable; the port 1 buffer stays full and scmdaccept[1]=0; the flit completes in the cycle rdy=1.
- Port 3 holds one buffered WR with rdy=0, then `i_pwr_tok_idle_req[3]`=1: no new accept; ack stays 0 until the flit is handshaken, then ack=1 and idle_val=1; dropping the request clears ack on the next cycle.
- Port 0 MCmd=3'b010: accepted; `o_cmd_err[0]`=1 sticky; no flit emitted; `i_noc_rst` clears the flag.
